// File: rtl/aes_pkg.sv
// AES Wishbone front-end shared definitions.
// Register map, CTRL/STATUS bit positions and FSM states.
package aes_pkg;

  localparam logic [7:0] OFF_KEY0   = 8'h00;
  localparam logic [7:0] OFF_DIN0   = 8'h10;
  localparam logic [7:0] OFF_DOUT0  = 8'h20;
  localparam logic [7:0] OFF_CTRL   = 8'h30;
  localparam logic [7:0] OFF_STATUS = 8'h34;

  localparam int CTRL_START   = 0;
  localparam int CTRL_DECRYPT = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } fsm_state_e;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_wb_ctrl_fsm.sv
// AES operation sequencer: launch, wait, completion.
// Owns the core watchdog and the busy/done/timeout flags.
module aes_wb_ctrl_fsm
  import aes_pkg::*;
#(
  parameter logic [15:0] CORE_TIMEOUT = 16'd1024
) (
  input  logic clock,
  input  logic reset,
  input  logic start_req,
  input  logic status_rd,
  input  logic core_done,
  output logic busy,
  output logic done,
  output logic timeout,
  output logic core_start,
  output logic dout_load
);

  fsm_state_e  state_q;
  logic [15:0] cnt_q;

  assign dout_load = (state_q == S_WAIT) && core_done;

  // Sequencer with registered flags and launch pulse
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      core_start <= 1'b0;
    end else begin
      core_start <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_req) begin
            state_q    <= S_LAUNCH;
            busy       <= 1'b1;
            done       <= 1'b0;
            timeout    <= 1'b0;
            core_start <= 1'b1;
          end
        end
        S_LAUNCH: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
        S_WAIT: begin
          if (core_done) begin
            state_q <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (cnt_q == CORE_TIMEOUT - 16'd1) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DONE: begin
          if (start_req) begin
            state_q    <= S_LAUNCH;
            busy       <= 1'b1;
            done       <= 1'b0;
            timeout    <= 1'b0;
            core_start <= 1'b1;
          end else if (status_rd) begin
            state_q <= S_IDLE;
            done    <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/aes_wb_frontend.sv
// Wishbone register front-end for an AES core.
// Optional IRQ output enabled by AES_WB_IRQ_EN.
module aes_wb_frontend
  import aes_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [15:0] CORE_TIMEOUT = 16'd1024
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_wbs_cyc_i,
  input  logic         io_wbs_stb_i,
  input  logic         io_wbs_we_i,
  input  logic [3:0]   io_wbs_sel_i,
  input  logic [31:0]  io_wbs_adr_i,
  input  logic [31:0]  io_wbs_dat_i,
  output logic         io_wbs_ack_o,
  output logic [31:0]  io_wbs_dat_o,
  output logic         core_start,
  output logic         core_decrypt,
  output logic [127:0] core_key,
  output logic [127:0] core_din,
  input  logic         core_done,
  input  logic [127:0] core_dout
`ifdef AES_WB_IRQ_EN
  ,
  output logic         irq
`endif
);

  logic [31:0] key_q  [4];
  logic [31:0] din_q  [4];
  logic [31:0] dout_q [4];
  logic        dec_q;
  logic        ack_q;
  logic [31:0] dat_q;

  logic        busy;
  logic        done;
  logic        timeout;
  logic        dout_load;

  logic        sel_hit;
  logic        accept;
  logic        wr_req;
  logic        rd_req;
  logic        wr_ok;
  logic [7:0]  off;
  logic [1:0]  widx;
  logic        aligned;
  logic        hit_key;
  logic        hit_din;
  logic        hit_dout;
  logic        hit_ctrl;
  logic        hit_stat;
  logic        start_req;
  logic        status_rd;
  logic [31:0] ctrl_word;
  logic [31:0] stat_word;
  logic [31:0] rd_data;

  assign sel_hit = io_wbs_cyc_i && io_wbs_stb_i
                && (io_wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign accept  = sel_hit && !ack_q;
  assign wr_req  = accept && io_wbs_we_i;
  assign rd_req  = accept && !io_wbs_we_i;
  assign wr_ok   = wr_req && !busy;

  assign off      = io_wbs_adr_i[7:0];
  assign widx     = off[3:2];
  assign aligned  = (off[1:0] == 2'b00);
  assign hit_key  = aligned && (off[7:4] == OFF_KEY0[7:4]);
  assign hit_din  = aligned && (off[7:4] == OFF_DIN0[7:4]);
  assign hit_dout = aligned && (off[7:4] == OFF_DOUT0[7:4]);
  assign hit_ctrl = (off == OFF_CTRL);
  assign hit_stat = (off == OFF_STATUS);

  assign start_req = wr_ok && hit_ctrl && io_wbs_sel_i[0]
                  && io_wbs_dat_i[CTRL_START];
  assign status_rd = rd_req && hit_stat;

  assign io_wbs_ack_o = ack_q;
  assign io_wbs_dat_o = dat_q;

  assign core_key = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign core_din = {din_q[0], din_q[1], din_q[2], din_q[3]};
  assign core_decrypt = dec_q;

  aes_wb_ctrl_fsm #(
    .CORE_TIMEOUT(CORE_TIMEOUT)
  ) u_fsm (
    .clock     (clock),
    .reset     (reset),
    .start_req (start_req),
    .status_rd (status_rd),
    .core_done (core_done),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .core_start(core_start),
    .dout_load (dout_load)
  );

`ifdef AES_WB_IRQ_EN
  logic irq_en_q;

  assign irq = done && irq_en_q;

  // Interrupt enable bit, locked while an operation runs
  always_ff @(posedge clock) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
    end else if (wr_ok && hit_ctrl && io_wbs_sel_i[0]) begin
      irq_en_q <= io_wbs_dat_i[CTRL_IRQ_EN];
    end
  end
`endif

  // CTRL and STATUS read images
  always_comb begin
    ctrl_word = '0;
    stat_word = '0;
    ctrl_word[CTRL_DECRYPT] = dec_q;
`ifdef AES_WB_IRQ_EN
    ctrl_word[CTRL_IRQ_EN] = irq_en_q;
`endif
    stat_word[STAT_BUSY]    = busy;
    stat_word[STAT_DONE]    = done;
    stat_word[STAT_TIMEOUT] = timeout;
  end

  // Read mux; unmapped offsets read as zero
  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      hit_key:  rd_data = key_q[widx];
      hit_din:  rd_data = din_q[widx];
      hit_dout: rd_data = dout_q[widx];
      hit_ctrl: rd_data = ctrl_word;
      hit_stat: rd_data = stat_word;
      default:  rd_data = '0;
    endcase
  end

  // Host-visible registers and result capture
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        key_q[i]  <= '0;
        din_q[i]  <= '0;
        dout_q[i] <= '0;
      end
      dec_q <= 1'b0;
    end else begin
      if (wr_ok && hit_key) begin
        key_q[widx] <= be_merge(key_q[widx], io_wbs_dat_i, io_wbs_sel_i);
      end
      if (wr_ok && hit_din) begin
        din_q[widx] <= be_merge(din_q[widx], io_wbs_dat_i, io_wbs_sel_i);
      end
      if (wr_ok && hit_ctrl && io_wbs_sel_i[0]) begin
        dec_q <= io_wbs_dat_i[CTRL_DECRYPT];
      end
      if (dout_load) begin
        for (int i = 0; i < 4; i++) begin
          dout_q[i] <= core_dout[127-32*i -: 32];
        end
      end
    end
  end

  // Single-cycle ack with data only in the ack cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= accept;
      dat_q <= rd_req ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_aes_wb_frontend.sv
// Self-checking bench for aes_wb_frontend.
// Directed scenarios plus randomized ops against a register-level model.
module tb_aes_wb_frontend;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         cyc = 1'b0;
  logic         stb = 1'b0;
  logic         we = 1'b0;
  logic [3:0]   sel = 4'h0;
  logic [31:0]  adr = '0;
  logic [31:0]  dat_i = '0;
  logic         ack;
  logic [31:0]  dat_o;
  logic         core_start;
  logic         core_decrypt;
  logic [127:0] core_key;
  logic [127:0] core_din;
  logic         core_done = 1'b0;
  logic [127:0] core_dout = '0;
`ifdef AES_WB_IRQ_EN
  logic         irq;
`endif

  always #5 clock = ~clock;

  aes_wb_frontend dut (
    .clock       (clock),
    .reset       (reset),
    .io_wbs_cyc_i(cyc),
    .io_wbs_stb_i(stb),
    .io_wbs_we_i (we),
    .io_wbs_sel_i(sel),
    .io_wbs_adr_i(adr),
    .io_wbs_dat_i(dat_i),
    .io_wbs_ack_o(ack),
    .io_wbs_dat_o(dat_o),
    .core_start  (core_start),
    .core_decrypt(core_decrypt),
    .core_key    (core_key),
    .core_din    (core_din),
    .core_done   (core_done),
    .core_dout   (core_dout)
`ifdef AES_WB_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  int checks = 0;
  int failures = 0;

  // register-level model of the host view
  logic [31:0] m_key [4];
  logic [31:0] m_din [4];
  logic [31:0] m_dout [4];
  bit m_dec, m_irq_en, m_busy, m_done, m_to;

  // core model
  bit           core_en = 0;
  int           core_lat = 10;
  logic [127:0] core_resp = '0;
  int           pend = 0;
  int           start_cnt = 0;
  int           done_cnt = 0;
  int           man_req = 0;
  int           man_ack = 0;
  logic [127:0] key_at_start = '0;
  logic [127:0] din_at_start = '0;
  logic         dec_at_start = 1'b0;

  always @(posedge clock) begin
    #1;
    core_done = 1'b0;
    if (core_start) begin
      start_cnt++;
      key_at_start = core_key;
      din_at_start = core_din;
      dec_at_start = core_decrypt;
      if (core_en) pend = core_lat;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        core_done = 1'b1;
        core_dout = core_resp;
        done_cnt++;
      end
    end
    if (man_req != man_ack) begin
      man_ack = man_req;
      core_done = 1'b1;
      core_dout = core_resp;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_key[i] = '0;
      m_din[i] = '0;
      m_dout[i] = '0;
    end
    m_dec = 0; m_irq_en = 0; m_busy = 0; m_done = 0; m_to = 0;
  endfunction

  function automatic void m_write(input logic [7:0] off,
                                  input logic [31:0] d,
                                  input logic [3:0] s);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{s[b]}};
    if (m_busy || off[1:0] != 2'b00) return;
    if (off < 8'h10) begin
      m_key[off[3:2]] = (m_key[off[3:2]] & ~mask) | (d & mask);
    end else if (off < 8'h20) begin
      m_din[off[3:2]] = (m_din[off[3:2]] & ~mask) | (d & mask);
    end else if (off == 8'h30 && s[0]) begin
      m_dec = d[1];
`ifdef AES_WB_IRQ_EN
      m_irq_en = d[2];
`endif
      if (d[0]) begin
        m_busy = 1; m_done = 0; m_to = 0;
      end
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] off);
    if (off[1:0] != 2'b00) return '0;
    if (off < 8'h10) return m_key[off[3:2]];
    if (off < 8'h20) return m_din[off[3:2]];
    if (off < 8'h30) return m_dout[off[3:2]];
    if (off == 8'h30) return {29'd0, m_irq_en, m_dec, 1'b0};
    if (off == 8'h34) return {29'd0, m_to, m_done, m_busy};
    return '0;
  endfunction

  function automatic void m_complete(input logic [127:0] r);
    m_busy = 0;
    m_done = 1;
    for (int w = 0; w < 4; w++) m_dout[w] = r[127-32*w -: 32];
  endfunction

  task automatic wb(input bit w, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] s,
                    output logic [31:0] rd, output int lat);
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
    lat = -1;
    rd = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock);
      #1;
      if (ack) begin
        lat = i;
        rd = dat_o;
        break;
      end
    end
    cyc = 0; stb = 0; we = 0; sel = 0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] r;
    int lat;
    m_write(off, d, s);
    wb(1'b1, {BASE[31:8], off}, d, s, r, lat);
    chk("wr_ack", lat > 0, 1);
  endtask

  task automatic rd_get(input logic [7:0] off, output logic [31:0] d,
                        output bit ok);
    int lat;
    wb(1'b0, {BASE[31:8], off}, '0, 4'hF, d, lat);
    ok = lat > 0;
    if (off == 8'h34 && m_done && !m_busy) m_done = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off);
    logic [31:0] exp, got;
    bit ok;
    exp = m_read(off);
    rd_get(off, got, ok);
    chk(tag, {ok, got}, {1'b1, exp});
  endtask

  task automatic wait_core(input int n0, input string tag);
    int i;
    i = 0;
    while (done_cnt == n0 && i < 300) begin
      @(posedge clock);
      i++;
    end
    repeat (2) @(posedge clock);
    #1;
    chk(tag, done_cnt, n0 + 1);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  s;
    bit          ok;
    int          lat;
    int          n0;
    int          sc0;
    bit          dec;

    m_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_start", core_start, 0);
    reset = 1;
    @(posedge clock);
    #1;
    rd_chk("rst_status", 8'h34);
    rd_chk("rst_key0", 8'h00);

    // byte enables
    wr(8'h00, 32'hFFFF_FFFF, 4'b0010);
    rd_get(8'h00, d, ok);
    chk("sel_key0", d, 32'h0000_FF00);
    rd_chk("sel_key0_m", 8'h00);

    // unmapped offset, out-of-window, ack spacing
    @(posedge clock);
    #1;
    wb(1'b0, {BASE[31:8], 8'h40}, '0, 4'hF, d, lat);
    chk("unmap_lat", lat, 1);
    chk("unmap_dat", d, 0);
    @(posedge clock);
    #1;
    chk("ack_gap", ack, 0);
    chk("dat_idle", dat_o, 0);
    wr(8'h40, 32'hDEAD_BEEF, 4'hF);
    wr(8'h20, 32'hDEAD_BEEF, 4'hF);
    rd_chk("dout0_ro", 8'h20);
    wb(1'b0, 32'h3000_0134, '0, 4'hF, d, lat);
    chk("oow_noack", lat > 0, 0);

    // known-answer vector
    wr(8'h00, 32'h0001_0203, 4'hF);
    wr(8'h04, 32'h0405_0607, 4'hF);
    wr(8'h08, 32'h0809_0a0b, 4'hF);
    wr(8'h0C, 32'h0c0d_0e0f, 4'hF);
    wr(8'h10, 32'h0011_2233, 4'hF);
    wr(8'h14, 32'h4455_6677, 4'hF);
    wr(8'h18, 32'h8899_aabb, 4'hF);
    wr(8'h1C, 32'hccdd_eeff, 4'hF);
    core_en = 1;
    core_lat = 10;
    core_resp = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    n0 = done_cnt;
    wr(8'h30, 32'h1, 4'hF);
    wait_core(n0, "vec_done");
    m_complete(core_resp);
    chk("vec_key", key_at_start,
        128'h00010203_04050607_08090a0b_0c0d0e0f);
    chk("vec_din", din_at_start,
        128'h00112233_44556677_8899aabb_ccddeeff);
    rd_get(8'h34, d, ok);
    chk("vec_status", d, 32'h2);
    rd_get(8'h20, d, ok);
    chk("vec_dout0", d, 32'h69c4e0d8);
    rd_chk("vec_dout3", 8'h2C);
    rd_get(8'h34, d, ok);
    chk("vec_reread", d, 32'h0);

    // writes and start while busy
    core_lat = 20;
    sc0 = start_cnt;
    n0 = done_cnt;
    wr(8'h30, 32'h1, 4'hF);
    wr(8'h10, 32'h1234_5678, 4'hF);
    wr(8'h30, 32'h3, 4'hF);
    wr(8'h00, 32'hA5A5_A5A5, 4'hF);
    rd_chk("busy_status", 8'h34);
    wait_core(n0, "busy_done");
    m_complete(core_resp);
    chk("busy_starts", start_cnt - sc0, 1);
    rd_get(8'h10, d, ok);
    chk("busy_din0", d, 32'h0011_2233);
    rd_chk("busy_ctrl", 8'h30);
    rd_chk("busy_clr", 8'h34);

    // randomized operations
    for (int it = 0; it < 5; it++) begin
      for (int w = 0; w < 4; w++) begin
        s = 4'($urandom_range(1, 15));
        wr(8'(4 * w), $urandom, s);
        s = 4'($urandom_range(1, 15));
        wr(8'(8'h10 + 4 * w), $urandom, s);
      end
      for (int w = 0; w < 8; w++) rd_chk("rnd_rb", 8'(4 * w));
      dec = 1'($urandom);
      wr(8'h30, {30'd0, dec, 1'b0}, 4'hF);
      rd_chk("rnd_ctrl", 8'h30);
      core_lat = $urandom_range(2, 15);
      core_resp = {$urandom, $urandom, $urandom, $urandom};
      n0 = done_cnt;
      wr(8'h30, {30'd0, dec, 1'b1}, 4'hF);
      wait_core(n0, "rnd_done");
      chk("rnd_key", key_at_start,
          {m_key[0], m_key[1], m_key[2], m_key[3]});
      chk("rnd_din", din_at_start,
          {m_din[0], m_din[1], m_din[2], m_din[3]});
      chk("rnd_dec", dec_at_start, m_dec);
      m_complete(core_resp);
      rd_chk("rnd_status", 8'h34);
      for (int w = 0; w < 4; w++) rd_chk("rnd_dout", 8'(8'h20 + 4 * w));
      rd_chk("rnd_clr", 8'h34);
    end

    // core_done outside WAIT is ignored
    core_resp = {$urandom, $urandom, $urandom, $urandom};
    man_req++;
    repeat (4) @(posedge clock);
    #1;
    rd_chk("stray_dout0", 8'h20);
    rd_chk("stray_status", 8'h34);

    // STATUS read colliding with core_done
    core_en = 0;
    core_resp = {$urandom, $urandom, $urandom, $urandom};
    wr(8'h30, 32'h1, 4'hF);
    repeat (5) @(posedge clock);
    @(posedge clock);
    man_req++;
    #1;
    rd_get(8'h34, d, ok);
    chk("race_read", {ok, d}, {1'b1, 32'h1});
    m_complete(core_resp);
    rd_chk("race_done", 8'h34);
    rd_chk("race_dout1", 8'h24);
    rd_chk("race_clr", 8'h34);

    // watchdog
    wr(8'h30, 32'h1, 4'hF);
    repeat (1010) @(posedge clock);
    #1;
    rd_chk("to_early", 8'h34);
    repeat (20) @(posedge clock);
    #1;
    m_busy = 0;
    m_to = 1;
    rd_get(8'h34, d, ok);
    chk("to_status", d, 32'h4);
    wr(8'h30, 32'h1, 4'hF);
    rd_get(8'h34, d, ok);
    chk("to_restart", d, 32'h1);

    // reset during WAIT with a request pending
    cyc = 1; stb = 1; we = 0; sel = 4'hF;
    adr = {BASE[31:8], 8'h34};
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk("rstw_noack", ack, 0);
    end
    chk("rstw_start", core_start, 0);
    chk("rstw_dat", dat_o, 0);
    cyc = 0; stb = 0;
    reset = 1;
    m_reset();
    @(posedge clock);
    #1;
    for (int w = 0; w < 12; w++) rd_chk("rstw_reg", 8'(4 * w));
    rd_chk("rstw_ctrl", 8'h30);
    rd_chk("rstw_status", 8'h34);
    core_resp = {$urandom, $urandom, $urandom, $urandom};
    man_req++;
    repeat (3) @(posedge clock);
    #1;
    rd_chk("late_status", 8'h34);
    rd_chk("late_dout0", 8'h20);

`ifdef AES_WB_IRQ_EN
    core_en = 1;
    core_lat = 6;
    wr(8'h30, 32'h4, 4'hF);
    rd_chk("irq_ctrl", 8'h30);
    n0 = done_cnt;
    wr(8'h30, 32'h5, 4'hF);
    wait_core(n0, "irq_done");
    m_complete(core_resp);
    chk("irq_high", irq, 1);
    rd_chk("irq_status", 8'h34);
    @(posedge clock);
    #1;
    chk("irq_low", irq, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_wb_frontend.md
AES_WB_FRONTEND -- requirements
Module: aes_wb_frontend

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, giving the Wishbone window base; bits [31:8] are decoded.
REQ-002 SHALL have parameter CORE_TIMEOUT, default 16'd1024, giving the maximum cycles in WAIT before an error is flagged.
REQ-003 Ports, in order:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-low.
REQ-004 Wishbone slave ports SHALL be:
- io_wbs_cyc_i, io_wbs_stb_i, io_wbs_we_i  in  1 each.
- io_wbs_sel_i  in  4.
- io_wbs_adr_i  in  32.
- io_wbs_dat_i  in  32.
- io_wbs_ack_o  out  1.
- io_wbs_dat_o  out  32.
REQ-005 Core-side ports SHALL be:
- core_start  out  1  one-cycle launch pulse.
- core_decrypt  out  1  mode, 1 = decrypt.
- core_key  out  128  key.
- core_din  out  128  input block.
- core_done  in  1  result-valid pulse.
- core_dout  in  128  result block.

Function
REQ-006 Register offsets (word 0 = bits [127:96]) SHALL be:
- KEY0-3 at 0x00-0x0C, RW.
- DIN0-3 at 0x10-0x1C, RW.
- DOUT0-3 at 0x20-0x2C, RO.
- CTRL at 0x30: bit0 start (write-1 pulse), bit1 decrypt (RW).
- STATUS at 0x34: bit0 busy, bit1 done, bit2 timeout (RO).
REQ-007 A cycle SHALL be selected when cyc & stb & adr[31:8] == BASE_ADDR[31:8].
REQ-008 io_wbs_ack_o SHALL assert exactly one cycle after a selected request and then deassert for at least one cycle; no back-to-back acks.
REQ-009 io_wbs_dat_o SHALL be valid in the ack cycle and 0 at all other times.
REQ-010 Writes SHALL honour io_wbs_sel_i per byte; reads SHALL ignore it.
REQ-011 An unmapped offset in the window SHALL be acked, SHALL read 0, and writes to it SHALL be dropped.
REQ-012 The FSM SHALL have states IDLE, LAUNCH, WAIT and DONE.
- IDLE -> LAUNCH on a CTRL write with bit0=1.
- LAUNCH -> WAIT after exactly 1 cycle; core_start=1 only in LAUNCH.
- WAIT -> DONE on core_done; DOUT latches core_dout in that same cycle.
- WAIT -> IDLE with timeout=1 when CORE_TIMEOUT cycles elapse without core_done.
- DONE -> IDLE on a STATUS read (clears done) or on a new start (goes directly to LAUNCH).
REQ-013 busy SHALL be 1 in LAUNCH and WAIT.
REQ-014 While busy, writes to KEY, DIN, CTRL.decrypt and CTRL.start SHALL be acked and ignored.
REQ-015 core_key, core_din and core_decrypt SHALL be driven continuously from their registers and are stable from LAUNCH through WAIT.
REQ-016 core_done outside WAIT SHALL be ignored; DOUT SHALL be unchanged.
REQ-017 If a STATUS read is acked in the same cycle core_done arrives, done SHALL be set, and that read SHALL return done=0.
REQ-018 A new start SHALL clear timeout and done.

Reset
REQ-019 While reset=0 at a clock edge, all registers SHALL clear to 0, the FSM SHALL go to IDLE, and ack, core_start and io_wbs_dat_o SHALL be 0.
REQ-020 Reset during WAIT SHALL abandon the operation; a later core_done SHALL be ignored per REQ-016.
REQ-021 A Wishbone request in progress when reset is applied SHALL be dropped without ack.

Configuration
REQ-022 With AES_WB_IRQ_EN defined, there SHALL be an output port irq (1 bit) and an IRQ_EN register bit (CTRL bit2); irq SHALL be high while done & IRQ_EN.
REQ-023 Without AES_WB_IRQ_EN, the irq port SHALL be absent and CTRL bit2 SHALL read 0 and ignore writes.

Structure
REQ-024 Package aes_pkg SHALL hold the register offset constants, the CTRL/STATUS bit indices and the FSM state enum.
REQ-025 The FSM plus timeout counter SHALL be a sub-module aes_wb_ctrl_fsm; register file and decode stay at top level.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Write KEY=000102..0f and DIN=00112233..ff, start, core model returns 69c4e0d8_6a7b0430_d8cdb780_70b4c55a after 10 cycles -> STATUS=0x2, DOUT0=0x69c4e0d8, and a STATUS reread gives 0x0.
- Write KEY0=0xFFFFFFFF with sel=4'b0010 -> KEY0 reads 0x0000FF00.
- Write DIN0=0x12345678 while busy, and start while busy -> DIN0 unchanged, exactly one core_start pulse seen.
- Core never answers -> STATUS=0x4 after 1024 WAIT cycles; a new start clears it to 0x1.
- Read offset 0x40 -> ack after 1 cycle, data 0; reset asserted mid-WAIT -> all registers 0, late core_done ignored.
- With AES_WB_IRQ_EN: IRQ_EN=1 then a completed operation -> irq=1 until the STATUS read.
